// File: rtl/ext_adc_ctrl.sv
// ext_adc_ctrl: dual SPI ADC scan sequencer with a DSP-bus read-back window.
//
// Both ADCs share SCLK/MOSI and are framed together by CS1n/CS2n. Each
// sequence scans channels 0..NUM_CH-1. Every frame is a SETUP half-period,
// 16 SCLK periods, a HOLD half-period and a QUIET gap. SCLK idles high and
// MISO is sampled on each rising SCLK edge.
//
// Ports:
//   CLK, RESET      system clock, asynchronous active-high reset
//   SOC             start-of-conversion level (rising edge starts a scan)
//   BUSY, DONE      scan in progress / one-cycle completion pulse
//   SCLK, MOSI      shared SPI clock and command line
//   MISO1, MISO2    per-ADC data inputs
//   CS1n, CS2n      per-ADC chip selects (active low)
//   Addr, CSn, OEn  DSP bus read side
//   RD_DATA         registered read data (0 when not selected)
//   RD_HIT          combinational window hit
module ext_adc_ctrl #(
  parameter int unsigned CLK_DIV      = 10,
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned QUIET_CYCLES = 4,
  parameter logic [13:0] BASE_ADDR    = 14'h0080
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SOC,
  output logic        BUSY,
  output logic        DONE,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO1,
  input  logic        MISO2,
  output logic        CS1n,
  output logic        CS2n,
  input  logic [13:0] Addr,
  input  logic        CSn,
  input  logic        OEn,
  output logic [15:0] RD_DATA,
  output logic        RD_HIT
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StQuiet} state_e;

  localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
  localparam logic [15:0] QuietLast = 16'(QUIET_CYCLES - 1);
  localparam logic [3:0]  LastCh    = 4'(NUM_CH - 1);

  function automatic logic [15:0] cmd_word(input logic [3:0] ch);
    return {4'b1000, ch, 8'h00};
  endfunction

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  ch_q, ch_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        soc_q, soc_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  seq_cnt_q, seq_cnt_d;
  logic [15:0] sr1_q, sr1_d;
  logic [15:0] sr2_q, sr2_d;
  logic [15:0] res1_q [16];
  logic [15:0] res1_d [16];
  logic [15:0] res2_q [16];
  logic [15:0] res2_d [16];
  logic [15:0] rd_data_q, rd_data_d;

  logic        soc_rise;
  logic [15:0] cmd;
  logic [13:0] off;
  logic        in_win;
  logic        rd_sel;
  logic        status_sel;
  logic [3:0]  k;
  logic        k_valid;
  logic [15:0] rd_word;

  assign soc_rise = SOC & ~soc_q;
  assign cmd      = cmd_word(ch_q);

  // Read window decode: 64 words starting at BASE_ADDR.
  assign off        = Addr - BASE_ADDR;
  assign in_win     = (Addr >= BASE_ADDR) && (off < 14'd64);
  assign rd_sel     = !CSn && !OEn && in_win;
  assign status_sel = (off == 14'h0020);
  assign k          = off[3:0];
  assign k_valid    = ({1'b0, k} < 5'(NUM_CH));

  always_comb begin
    rd_word = '0;
    unique case (off[5:4])
      2'b00:   if (k_valid) rd_word = res1_q[k];
      2'b01:   if (k_valid) rd_word = res2_q[k];
      2'b10:   if (status_sel) rd_word = {overrun_q, busy_q, 6'b0, seq_cnt_q};
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    ch_d      = ch_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    soc_d     = SOC;
    seq_cnt_d = seq_cnt_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    res1_d    = res1_q;
    res2_d    = res2_q;
    rd_data_d = rd_sel ? rd_word : 16'h0000;

    // A status read clears OVERRUN; a same-cycle overrun wins.
    overrun_d = overrun_q;
    if (rd_sel && status_sel) overrun_d = 1'b0;
    if (soc_rise && busy_q)   overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (soc_rise) begin
          state_d = StSetup;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          ch_d    = '0;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          mosi_d  = cmd_word(4'd0) >> 15;
        end
      end
      StSetup: begin
        if (cnt_q == DivLast) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: capture both MISO lines, present next command bit.
            sclk_d = 1'b1;
            sr1_d  = {sr1_q[14:0], MISO1};
            sr2_d  = {sr2_q[14:0], MISO2};
            mosi_d = (bit_q == 4'd15) ? 1'b0 : cmd[4'd14 - bit_q];
          end else if (bit_q == 4'd15) begin
            state_d      = StHold;
            res1_d[ch_q] = sr1_q;
            res2_d[ch_q] = sr2_q;
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StHold: begin
        if (cnt_q == DivLast) begin
          state_d = StQuiet;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StQuiet: begin
        if (cnt_q == QuietLast) begin
          cnt_d = '0;
          if (ch_q < LastCh) begin
            state_d = StSetup;
            ch_d    = ch_q + 4'd1;
            cs_n_d  = 1'b0;
            mosi_d  = cmd_word(ch_q + 4'd1) >> 15;
          end else begin
            state_d   = StIdle;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            seq_cnt_d = seq_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      ch_q      <= '0;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      soc_q     <= 1'b0;
      overrun_q <= 1'b0;
      seq_cnt_q <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      res1_q    <= '{default: '0};
      res2_q    <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ch_q      <= ch_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      soc_q     <= soc_d;
      overrun_q <= overrun_d;
      seq_cnt_q <= seq_cnt_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      res1_q    <= res1_d;
      res2_q    <= res2_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign CS1n    = cs_n_q;
  assign CS2n    = cs_n_q;
  assign RD_DATA = rd_data_q;
  assign RD_HIT  = rd_sel;

endmodule
